// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send, then shifts one
// command byte with odd parity and stop out on device-generated clocks and checks the ACK bit.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_INHIBIT = 3'd1;
    localparam logic [2:0] S_RTS     = 3'd2;
    localparam logic [2:0] S_SEND    = 3'd3;
    localparam logic [2:0] S_ACK     = 3'd4;
    localparam logic [2:0] S_WAIT    = 3'd5;
    localparam logic [2:0] S_DONE    = 3'd6;

    logic [7:0]       filt;
    logic             fall;
    logic             data_meta;
    logic             data_sync;
    logic [2:0]       state;
    logic [9:0]       frame;
    logic [3:0]       bitcnt;
    logic [CNT_W-1:0] cnt;
    logic             err;
    logic             clk_oe_r;
    logic             data_oe_r;

    // A fall needs four stable highs followed by four stable lows, so short glitches are
    // rejected. The filter starts all-ones so the idle bus never looks like an edge.
    // NOTE: sequential state uses non-blocking assignments only, so every flop samples
    // pre-edge values and simulation order cannot change the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            filt      <= 8'hFF;
            fall      <= 1'b0;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            filt      <= {ps2_clk_in, filt[7:1]};
            fall      <= (filt == 8'b00001111);
            data_meta <= ps2_data_in;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            frame     <= '0;
            bitcnt    <= '0;
            cnt       <= '0;
            err       <= 1'b0;
            clk_oe_r  <= 1'b0;
            data_oe_r <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (tx_start) begin
                        frame     <= {1'b1, ~^tx_data, tx_data};
                        bitcnt    <= '0;
                        cnt       <= '0;
                        err       <= 1'b0;
                        clk_oe_r  <= 1'b1;
                        data_oe_r <= 1'b0;
                        state     <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    if (cnt == INH_LAST) begin
                        cnt       <= '0;
                        data_oe_r <= 1'b1;
                        state     <= S_RTS;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_RTS: begin
                    clk_oe_r <= 1'b0;
                    cnt      <= '0;
                    state    <= S_SEND;
                end
                S_SEND: begin
                    // Start bit stays on the line until the first device fall.
                    if (fall) begin
                        cnt       <= '0;
                        data_oe_r <= ~frame[0];
                        frame     <= {1'b1, frame[9:1]};
                        bitcnt    <= bitcnt + 4'd1;
                        if (bitcnt == 4'd9) state <= S_ACK;
                    end else if (cnt == TMO_LAST) begin
                        data_oe_r <= 1'b0;
                        err       <= 1'b1;
                        state     <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_ACK: begin
                    if (fall) begin
                        cnt   <= '0;
                        err   <= data_sync;
                        state <= S_WAIT;
                    end else if (cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_WAIT: begin
                    if (filt == 8'hFF && data_sync) begin
                        state <= S_DONE;
                    end else if (fall) begin
                        cnt <= '0;
                    end else if (cnt == TMO_LAST) begin
                        err   <= 1'b1;
                        state <= S_DONE;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                S_DONE: begin
                    clk_oe_r  <= 1'b0;
                    data_oe_r <= 1'b0;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign tx_busy     = (state != S_IDLE);
    assign tx_done     = (state == S_DONE);
    assign tx_error    = (state == S_DONE) & err;
    assign ps2_clk_oe  = clk_oe_r;
    assign ps2_data_oe = data_oe_r;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a PS/2 device model clocks frames out of the host and expected
// bytes/error flags are queued at tx_start and compared when tx_done appears.
module tb_ps2_host_tx;

    localparam int INH = 40;
    localparam int TMO = 300;
    localparam int H   = 15;

    typedef struct packed {
        logic [7:0] data;
        logic       err;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       tx_busy, tx_done, tx_error;
    logic       ps2_clk_oe, ps2_data_oe;
    logic       dev_clk = 1'b1;
    logic       dev_data = 1'b1;
    logic       ps2_clk_in, ps2_data_in;

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t sb[$];

    assign ps2_clk_in  = ps2_clk_oe  ? 1'b0 : dev_clk;
    assign ps2_data_in = ps2_data_oe ? 1'b0 : dev_data;

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .tx_done(tx_done), .tx_error(tx_error),
        .ps2_clk_in(ps2_clk_in), .ps2_data_in(ps2_data_in),
        .ps2_clk_oe(ps2_clk_oe), .ps2_data_oe(ps2_data_oe)
    );

    always #5 clk = ~clk;

    initial begin
        #800_000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    task automatic start_tx(input logic [7:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // Counts the inhibit phase, then checks the one-cycle RTS and the SEND entry.
    task automatic wait_rts(input string tag);
        int inh = 0;
        while (ps2_clk_oe && !ps2_data_oe && inh < INH + 20) begin
            inh++;
            @(negedge clk);
        end
        n_checks++;
        if (inh !== INH) $display("FAIL %s inhibit_len: got %0d want %0d", tag, inh, INH);
        else n_pass++;
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b11)
            $display("FAIL %s rts_oe: got %b want 11", tag, {ps2_clk_oe, ps2_data_oe});
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b01)
            $display("FAIL %s send_oe: got %b want 01", tag, {ps2_clk_oe, ps2_data_oe});
        else n_pass++;
    endtask

    // Device model: n_falls clock pulses, samples the line at each rising edge, drives ACK
    // (or leaves data high) before the 11th fall. Optional 3-cycle glitch after fall glitch_at.
    task automatic run_device(input int glitch_at, input int n_falls, input bit ack,
                              output logic [9:0] bits);
        bits = '0;
        repeat (H) @(negedge clk);
        for (int i = 1; i <= n_falls; i++) begin
            if (i == 11) dev_data = ack ? 1'b0 : 1'b1;
            dev_clk = 1'b0;
            repeat (H) @(negedge clk);
            dev_clk = 1'b1;
            if (i <= 10) bits[i-1] = ps2_data_in;
            if (i < n_falls) begin
                if (i == glitch_at) begin
                    repeat (5) @(negedge clk);
                    dev_clk = 1'b0;
                    repeat (3) @(negedge clk);
                    dev_clk = 1'b1;
                    repeat (H - 8) @(negedge clk);
                end else begin
                    repeat (H) @(negedge clk);
                end
            end
        end
    endtask

    task automatic do_frame(input logic [7:0] d, input bit ack, input int glitch_at,
                            input bit inject_busy, input bit inject_done, input string tag);
        logic [9:0] bits;
        exp_t       e;
        bit         saw;
        logic       err_seen;
        logic       exp_par;
        int         ones;
        int         extra;
        start_tx(d);
        e.data = d;
        e.err  = ~ack;
        sb.push_back(e);
        n_checks++;
        if (tx_busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", tag, tx_busy);
        else n_pass++;
        wait_rts(tag);
        if (inject_busy) begin
            tx_data  = 8'h01;
            tx_start = 1'b1;
            @(negedge clk);
            tx_start = 1'b0;
        end
        run_device(glitch_at, 11, ack, bits);
        saw      = 1'b0;
        err_seen = 1'bx;
        for (int n = 0; n < 400 && !saw; n++) begin
            @(negedge clk);
            if (n == H) dev_data = 1'b1;
            if (tx_done) begin
                saw      = 1'b1;
                err_seen = tx_error;
            end
        end
        dev_data = 1'b1;
        if (inject_done) begin
            tx_data  = 8'h77;
            tx_start = 1'b1;
        end
        @(negedge clk);
        tx_start = 1'b0;
        n_checks++;
        if (saw !== 1'b1) $display("FAIL %s done_seen: got %b want 1", tag, saw);
        else n_pass++;
        e    = sb.pop_front();
        ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(e.data[b]);
        exp_par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        n_checks++;
        if (bits[7:0] !== e.data) $display("FAIL %s data: got %h want %h", tag, bits[7:0], e.data);
        else n_pass++;
        n_checks++;
        if (bits[8] !== exp_par) $display("FAIL %s parity: got %b want %b", tag, bits[8], exp_par);
        else n_pass++;
        n_checks++;
        if (bits[9] !== 1'b1) $display("FAIL %s stop: got %b want 1", tag, bits[9]);
        else n_pass++;
        n_checks++;
        if (err_seen !== e.err) $display("FAIL %s tx_error: got %b want %b", tag, err_seen, e.err);
        else n_pass++;
        n_checks++;
        if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000)
            $display("FAIL %s idle_after_done: got %b want 000", tag, {tx_busy, ps2_clk_oe, ps2_data_oe});
        else n_pass++;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx_done) extra++;
        end
        n_checks++;
        if (extra !== 0) $display("FAIL %s extra_done: got %0d want 0", tag, extra);
        else n_pass++;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if ({tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe} !== 5'b0)
            $display("FAIL reset_outputs: got %b want 00000",
                     {tx_busy, tx_done, tx_error, ps2_clk_oe, ps2_data_oe});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if ({tx_busy, tx_done, ps2_clk_oe, ps2_data_oe} !== 4'b0)
            $display("FAIL idle_after_reset: got %b want 0000",
                     {tx_busy, tx_done, ps2_clk_oe, ps2_data_oe});
        else n_pass++;
    endtask

    task automatic test_send_ack();
        do_frame(8'hED, 1'b1, 0, 1'b0, 1'b0, "ed_ack");
    endtask

    task automatic test_back_to_back();
        do_frame(8'h00, 1'b1, 0, 1'b1, 1'b1, "b2b_00");
        do_frame(8'h01, 1'b1, 0, 1'b0, 1'b0, "b2b_01");
    endtask

    task automatic test_nack();
        do_frame(8'hF4, 1'b0, 0, 1'b0, 1'b0, "nack");
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n = 0;
        start_tx(8'hA5);
        e.data = 8'hA5;
        e.err  = 1'b1;
        sb.push_back(e);
        wait_rts("timeout");
        while (!tx_done && n < TMO + 50) begin
            @(negedge clk);
            n++;
        end
        e = sb.pop_front();
        n_checks++;
        if (n !== TMO) $display("FAIL timeout_latency: got %0d want %0d", n, TMO);
        else n_pass++;
        n_checks++;
        if (tx_error !== e.err) $display("FAIL timeout_error: got %b want %b", tx_error, e.err);
        else n_pass++;
        n_checks++;
        if ({ps2_clk_oe, ps2_data_oe} !== 2'b00)
            $display("FAIL timeout_oe: got %b want 00", {ps2_clk_oe, ps2_data_oe});
        else n_pass++;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_glitch();
        do_frame(8'h3C, 1'b1, 4, 1'b0, 1'b0, "glitch");
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] bits;
        start_tx(8'h52);
        wait_rts("midrst");
        run_device(0, 4, 1'b1, bits);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({tx_busy, ps2_clk_oe, ps2_data_oe} !== 3'b000)
            $display("FAIL midrst_release: got %b want 000", {tx_busy, ps2_clk_oe, ps2_data_oe});
        else n_pass++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        n_checks++;
        if (tx_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", tx_busy);
        else n_pass++;
        do_frame(8'hFF, 1'b1, 0, 1'b0, 1'b0, "after_rst");
    endtask

    initial begin
        test_reset();
        test_send_ack();
        test_back_to_back();
        test_nack();
        test_timeout();
        test_glitch();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
